// File: rtl/soc_bus_hub.sv
// SoC glue: CPU bus decode onto RAM/VRAM, derived clock generation and
// a scanned 4-digit seven-segment display of one of eight debug words.
module soc_bus_hub #(
    parameter int HALF_5MHZ  = 10,
    parameter int HALF_1MS   = 50_000,
    parameter int HALF_10MS  = 500_000,
    parameter int HALF_100MS = 5_000_000,
    parameter int SCAN_BIT   = 18
) (
    input  logic        mclk,
    input  logic        clr,
    input  logic        mem_w,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu2bus,
    output logic [31:0] bus2cpu,
    input  logic [31:0] ram2bus,
    output logic        ram_w,
    output logic [11:0] ram_address,
    output logic [31:0] bus2ram,
    input  logic [7:0]  vram2bus,
    output logic        vram_w,
    output logic [15:0] vram_address,
    output logic [7:0]  bus2vram,
    output logic        clk25,
    output logic        clk5mhz,
    output logic        clk1ms,
    output logic        clk10ms,
    output logic        clk100ms,
    output logic        clk190,
    input  logic        high,
    input  logic [2:0]  sel,
    input  logic [31:0] input0,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic [31:0] input3,
    input  logic [31:0] input4,
    input  logic [31:0] input5,
    input  logic [31:0] input6,
    input  logic [31:0] input7,
    output logic [6:0]  a_to_g,
    output logic [3:0]  an,
    output logic        dp
);

    logic        w_is_vram;
    logic [31:0] r_free_cnt;
    logic [31:0] w_free_next;
    logic        w_scan_rise;
    logic [1:0]  r_idx;
    logic [3:0]  w_div_out;
    logic [31:0] w_word;
    logic [15:0] w_half;
    logic [3:0]  w_nibble;

    // Only the 0xC000xxxx window maps to VRAM; everything else goes to RAM.
    assign w_is_vram    = (cpu_address[31:16] == 16'hC000);
    assign ram_address  = cpu_address[13:2];
    assign vram_address = cpu_address[15:0];
    assign bus2ram      = cpu2bus;
    assign bus2vram     = cpu2bus[7:0];
    assign ram_w        = mem_w & ~w_is_vram;
    assign vram_w       = mem_w & w_is_vram;
    assign bus2cpu      = w_is_vram ? {24'h0, vram2bus} : ram2bus;

    assign w_free_next = r_free_cnt + 32'd1;
    // Detect the 0->1 transition on the value being loaded, so idx moves on the same edge.
    assign w_scan_rise = w_free_next[SCAN_BIT] & ~r_free_cnt[SCAN_BIT];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge mclk) begin
        if (clr) begin
            r_free_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_free_cnt <= w_free_next;
            if (w_scan_rise)
                r_idx <= r_idx + 2'd1;
        end
    end

    assign clk25  = r_free_cnt[1];
    assign clk190 = r_free_cnt[SCAN_BIT];

    for (genvar g = 0; g < 4; g++) begin : g_div
        localparam int HALF = (g == 0) ? HALF_5MHZ :
                              (g == 1) ? HALF_1MS  :
                              (g == 2) ? HALF_10MS : HALF_100MS;
        localparam logic [31:0] L_TOP = 32'(HALF - 1);
        logic [31:0] r_cnt;
        logic        r_tgl;

        always_ff @(posedge mclk) begin
            if (clr) begin
                r_cnt <= '0;
                r_tgl <= 1'b0;
            end else if (r_cnt == L_TOP) begin
                r_cnt <= '0;
                r_tgl <= ~r_tgl;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign w_div_out[g] = r_tgl;
    end

    assign clk5mhz  = w_div_out[0];
    assign clk1ms   = w_div_out[1];
    assign clk10ms  = w_div_out[2];
    assign clk100ms = w_div_out[3];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_word = input0;
        case (sel)
            3'd1: w_word = input1;
            3'd2: w_word = input2;
            3'd3: w_word = input3;
            3'd4: w_word = input4;
            3'd5: w_word = input5;
            3'd6: w_word = input6;
            3'd7: w_word = input7;
            default: w_word = input0;
        endcase
    end

    assign w_half = high ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_nibble = w_half[3:0];
        case (r_idx)
            2'd1: w_nibble = w_half[7:4];
            2'd2: w_nibble = w_half[11:8];
            2'd3: w_nibble = w_half[15:12];
            default: w_nibble = w_half[3:0];
        endcase
    end

    assign an = ~(4'b0001 << r_idx);
    assign dp = 1'b1;

    always_comb begin
        a_to_g = 7'b1111111;
        case (w_nibble)
            4'h0: a_to_g = 7'b0000001;
            4'h1: a_to_g = 7'b1001111;
            4'h2: a_to_g = 7'b0010010;
            4'h3: a_to_g = 7'b0000110;
            4'h4: a_to_g = 7'b1001100;
            4'h5: a_to_g = 7'b0100100;
            4'h6: a_to_g = 7'b0100000;
            4'h7: a_to_g = 7'b0001111;
            4'h8: a_to_g = 7'b0000000;
            4'h9: a_to_g = 7'b0000100;
            4'hA: a_to_g = 7'b0001000;
            4'hB: a_to_g = 7'b1100000;
            4'hC: a_to_g = 7'b0110001;
            4'hD: a_to_g = 7'b1000010;
            4'hE: a_to_g = 7'b0110000;
            4'hF: a_to_g = 7'b0111000;
            default: a_to_g = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_soc_bus_hub.sv
// Scoreboard bench for soc_bus_hub: stimulus queues expected values, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_soc_bus_hub;

    typedef enum logic [3:0] {
        F_BUS2CPU, F_RAM_W, F_RAM_ADDR, F_BUS2RAM, F_VRAM_W, F_VRAM_ADDR,
        F_BUS2VRAM, F_CLKS, F_AN, F_SEG, F_DP
    } field_e;

    typedef struct {
        field_e      field;
        logic [31:0] value;
        string       name;
    } exp_t;

    logic        mclk = 1'b0;
    logic        clr = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu2bus = '0;
    logic [31:0] bus2cpu;
    logic [31:0] ram2bus = '0;
    logic        ram_w;
    logic [11:0] ram_address;
    logic [31:0] bus2ram;
    logic [7:0]  vram2bus = '0;
    logic        vram_w;
    logic [15:0] vram_address;
    logic [7:0]  bus2vram;
    logic        clk25, clk5mhz, clk1ms, clk10ms, clk100ms, clk190;
    logic        high = 1'b0;
    logic [2:0]  sel = 3'd2;
    logic [31:0] inputs [8];
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    soc_bus_hub #(
        .HALF_5MHZ(10), .HALF_1MS(3), .HALF_10MS(5), .HALF_100MS(7), .SCAN_BIT(2)
    ) dut (
        .mclk(mclk), .clr(clr), .mem_w(mem_w), .cpu_address(cpu_address),
        .cpu2bus(cpu2bus), .bus2cpu(bus2cpu), .ram2bus(ram2bus),
        .ram_w(ram_w), .ram_address(ram_address), .bus2ram(bus2ram),
        .vram2bus(vram2bus), .vram_w(vram_w), .vram_address(vram_address),
        .bus2vram(bus2vram), .clk25(clk25), .clk5mhz(clk5mhz), .clk1ms(clk1ms),
        .clk10ms(clk10ms), .clk100ms(clk100ms), .clk190(clk190),
        .high(high), .sel(sel),
        .input0(inputs[0]), .input1(inputs[1]), .input2(inputs[2]), .input3(inputs[3]),
        .input4(inputs[4]), .input5(inputs[5]), .input6(inputs[6]), .input7(inputs[7]),
        .a_to_g(a_to_g), .an(an), .dp(dp)
    );

    always #5 mclk = ~mclk;

    function automatic logic [31:0] actual(input field_e f);
        case (f)
            F_BUS2CPU:   return bus2cpu;
            F_RAM_W:     return {31'd0, ram_w};
            F_RAM_ADDR:  return {20'd0, ram_address};
            F_BUS2RAM:   return bus2ram;
            F_VRAM_W:    return {31'd0, vram_w};
            F_VRAM_ADDR: return {16'd0, vram_address};
            F_BUS2VRAM:  return {24'd0, bus2vram};
            F_CLKS:      return {26'd0, clk25, clk5mhz, clk1ms, clk10ms, clk100ms, clk190};
            F_AN:        return {28'd0, an};
            F_SEG:       return {25'd0, a_to_g};
            F_DP:        return {31'd0, dp};
            default:     return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: outputs are settled mid-cycle, so compare everything queued at each falling edge.
    always @(negedge mclk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.field);
            n_checks++;
            if (a !== e.value) begin
                n_errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, a, e.value, $time);
            end
        end
    end

    task automatic expect_val(input field_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.field = f;
        e.value = v;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge mclk);
        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        clr = 1'b1;
        step(edges);
        clr = 1'b0;
    endtask

    // Expected {clk25,clk5mhz,clk1ms,clk10ms,clk100ms,clk190} k edges after reset release.
    function automatic logic [31:0] clks_at(input int k);
        logic [5:0] v;
        v[5] = ((k / 2) % 2) == 1;
        v[4] = ((k / 10) % 2) == 1;
        v[3] = ((k / 3) % 2) == 1;
        v[2] = ((k / 5) % 2) == 1;
        v[1] = ((k / 7) % 2) == 1;
        v[0] = ((k / 4) % 2) == 1;
        return {26'd0, v};
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) inputs[i] = 32'h0;
        inputs[2] = 32'hABCD_1234;
        inputs[7] = 32'h0000_00FF;

        // Reset: single edge, then held for 5 edges
        do_reset(1);
        clr = 1'b1;
        expect_val(F_CLKS, 32'h0, "reset_clks");
        expect_val(F_AN, 32'hE, "reset_an");
        expect_val(F_DP, 32'h1, "reset_dp");
        drain();
        step(5);
        expect_val(F_CLKS, 32'h0, "reset_hold_clks");
        expect_val(F_AN, 32'hE, "reset_hold_an");
        drain();
        clr = 1'b0;

        // RAM write and read
        cpu_address = 32'h0000_0104; mem_w = 1'b1; cpu2bus = 32'hDEAD_BEEF; ram2bus = 32'h1234_5678;
        #1;
        expect_val(F_RAM_W, 32'h1, "ram_w");
        expect_val(F_VRAM_W, 32'h0, "ram_vram_w");
        expect_val(F_RAM_ADDR, 32'h041, "ram_addr");
        expect_val(F_BUS2RAM, 32'hDEAD_BEEF, "bus2ram");
        expect_val(F_BUS2CPU, 32'h1234_5678, "ram_rd");
        drain();

        // VRAM write, then read
        cpu_address = 32'hC000_12A5; cpu2bus = 32'h0000_005A; mem_w = 1'b1; vram2bus = 8'h3C;
        #1;
        expect_val(F_VRAM_W, 32'h1, "vram_w");
        expect_val(F_RAM_W, 32'h0, "vram_ram_w");
        expect_val(F_VRAM_ADDR, 32'h12A5, "vram_addr");
        expect_val(F_BUS2VRAM, 32'h5A, "bus2vram");
        drain();
        mem_w = 1'b0;
        #1;
        expect_val(F_BUS2CPU, 32'h0000_003C, "vram_rd");
        expect_val(F_VRAM_W, 32'h0, "vram_rd_vram_w");
        expect_val(F_RAM_W, 32'h0, "vram_rd_ram_w");
        drain();

        // Window boundaries: just above and below the VRAM page are RAM
        cpu_address = 32'hC001_0000; mem_w = 1'b1;
        #1;
        expect_val(F_RAM_W, 32'h1, "above_vram_ram_w");
        expect_val(F_VRAM_W, 32'h0, "above_vram_vram_w");
        expect_val(F_BUS2CPU, 32'h1234_5678, "above_vram_rd");
        drain();
        cpu_address = 32'hBFFF_FFFC;
        #1;
        expect_val(F_RAM_W, 32'h1, "below_vram_ram_w");
        expect_val(F_RAM_ADDR, 32'hFFF, "below_vram_addr");
        drain();
        mem_w = 1'b0;

        // Dividers, with a mid-count reset after edge 6
        do_reset(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            expect_val(F_CLKS, clks_at(k), $sformatf("div_pre_k%0d", k));
        end
        do_reset(1);
        expect_val(F_CLKS, 32'h0, "div_midreset_clks");
        expect_val(F_AN, 32'hE, "div_midreset_an");
        for (int k = 1; k <= 30; k++) begin
            step(1);
            expect_val(F_CLKS, clks_at(k), $sformatf("div_k%0d", k));
        end
        drain();

        // Display scan on input2 = 0xABCD1234, SCAN_BIT = 2
        sel = 3'd2; high = 1'b0;
        do_reset(1);
        expect_val(F_AN, 32'hE, "scan0_an");
        expect_val(F_SEG, 32'h4C, "scan0_seg");
        drain();
        step(3);
        expect_val(F_AN, 32'hE, "scan_pre_an");
        drain();
        step(1);
        expect_val(F_AN, 32'hD, "scan1_an");
        expect_val(F_SEG, 32'h06, "scan1_seg");
        drain();
        step(8);
        expect_val(F_AN, 32'hB, "scan2_an");
        expect_val(F_SEG, 32'h12, "scan2_seg");
        drain();
        step(8);
        expect_val(F_AN, 32'h7, "scan3_an");
        expect_val(F_SEG, 32'h4F, "scan3_seg");
        drain();
        step(8);
        expect_val(F_AN, 32'hE, "scan_wrap_an");
        expect_val(F_SEG, 32'h4C, "scan_wrap_seg");
        drain();
        high = 1'b1;
        #1;
        expect_val(F_SEG, 32'h42, "high_seg_d");
        drain();

        // Select word 7 while idx = 0
        do_reset(1);
        sel = 3'd7; high = 1'b0;
        #1;
        expect_val(F_AN, 32'hE, "sel7_an");
        expect_val(F_SEG, 32'h38, "sel7_seg_F");
        drain();
        high = 1'b1;
        #1;
        expect_val(F_SEG, 32'h01, "sel7_high_seg_0");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
